// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the tracked hazard controller.
// Forwarding select codes and the md_op encoding seen at the D stage.
package hazard_pkg;

  // D-stage compare operand source
  typedef enum logic [1:0] {
    FW_CMP_RF = 2'd0,
    FW_CMP_W  = 2'd1,
    FW_CMP_M  = 2'd2,
    FW_CMP_E  = 2'd3
  } fw_cmp_t;

  // E-stage ALU operand source
  typedef enum logic [1:0] {
    FW_ALU_REG = 2'd0,
    FW_ALU_W   = 2'd1,
    FW_ALU_M   = 2'd2
  } fw_alu_t;

  // Multiply/divide operation class of the instruction in D
  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_USE  = 2'd3
  } md_op_t;

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: counts down the busy window of the multiply/divide unit.
// A start seen while already busy is ignored; the count keeps running down.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  output logic busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Load on a start when idle, otherwise run down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end else if (start_mult) begin
      count <= CNT_W'(MULT_CYCLES);
    end else if (start_div) begin
      count <= CNT_W'(DIV_CYCLES);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl_tracked.sv
// hazard_ctrl_tracked: forwarding/stall controller with its own E/M/W shadow
// pipeline built from D-stage information only.
// Optional feature macro: HAZARD_MD_EN adds multiply/divide busy tracking
// (md_op shadow, busy counter and the MD stall). Without it md_op_d is
// ignored and md_busy is 0.
module hazard_ctrl_tracked
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int T_W         = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] a1_d,
  input  logic [REG_AW-1:0] a2_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic              we_d,
  input  logic [T_W-1:0]    tnew_d,
  input  logic [1:0]        md_op_d,
  output logic [1:0]        fw_cmp_rs,
  output logic [1:0]        fw_cmp_rt,
  output logic [1:0]        fw_alu_rs,
  output logic [1:0]        fw_alu_rt,
  output logic              fw_dm_rt,
  output logic              stall,
  output logic              md_busy
);

  // Shadow stages: only the fields some decision actually reads are kept.
  logic [REG_AW-1:0] a1_e, a2_e, a3_e;
  logic              we_e;
  logic [T_W-1:0]    tnew_e;
  logic [REG_AW-1:0] a2_m, a3_m;
  logic              we_m;
  logic [T_W-1:0]    tnew_m;
  logic [REG_AW-1:0] a3_w;
  logic              we_w;

  logic data_stall;
  logic md_stall;

  // A register matches a stage when that stage writes it and it is not $0.
  function automatic logic hit(input logic [REG_AW-1:0] addr,
                               input logic [REG_AW-1:0] a3,
                               input logic              we);
    return we && (a3 != '0) && (addr == a3);
  endfunction

  logic rs_hit_e, rs_hit_m, rs_hit_w, rt_hit_e, rt_hit_m, rt_hit_w;
  logic alu_rs_hit_m, alu_rs_hit_w, alu_rt_hit_m, alu_rt_hit_w;
  logic ready_e, ready_m;

  assign rs_hit_e     = hit(a1_d, a3_e, we_e);
  assign rs_hit_m     = hit(a1_d, a3_m, we_m);
  assign rs_hit_w     = hit(a1_d, a3_w, we_w);
  assign rt_hit_e     = hit(a2_d, a3_e, we_e);
  assign rt_hit_m     = hit(a2_d, a3_m, we_m);
  assign rt_hit_w     = hit(a2_d, a3_w, we_w);
  assign alu_rs_hit_m = hit(a1_e, a3_m, we_m);
  assign alu_rs_hit_w = hit(a1_e, a3_w, we_w);
  assign alu_rt_hit_m = hit(a2_e, a3_m, we_m);
  assign alu_rt_hit_w = hit(a2_e, a3_w, we_w);
  assign ready_e      = (tnew_e == '0);
  assign ready_m      = (tnew_m == '0);

  // Forwarding selects: nearest stage whose result is already available wins.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    fw_cmp_rs = FW_CMP_RF;
    fw_cmp_rt = FW_CMP_RF;
    fw_alu_rs = FW_ALU_REG;
    fw_alu_rt = FW_ALU_REG;
    if (rs_hit_e && ready_e)      fw_cmp_rs = FW_CMP_E;
    else if (rs_hit_m && ready_m) fw_cmp_rs = FW_CMP_M;
    else if (rs_hit_w)            fw_cmp_rs = FW_CMP_W;
    if (rt_hit_e && ready_e)      fw_cmp_rt = FW_CMP_E;
    else if (rt_hit_m && ready_m) fw_cmp_rt = FW_CMP_M;
    else if (rt_hit_w)            fw_cmp_rt = FW_CMP_W;
    if (alu_rs_hit_m && ready_m)  fw_alu_rs = FW_ALU_M;
    else if (alu_rs_hit_w)        fw_alu_rs = FW_ALU_W;
    if (alu_rt_hit_m && ready_m)  fw_alu_rt = FW_ALU_M;
    else if (alu_rt_hit_w)        fw_alu_rt = FW_ALU_W;
  end

  assign fw_dm_rt = hit(a2_m, a3_w, we_w);

  // A reader must wait while a producer ahead of it needs longer than it can.
  assign data_stall = (rs_hit_e && (tuse_rs_d < tnew_e)) ||
                      (rs_hit_m && (tuse_rs_d < tnew_m)) ||
                      (rt_hit_e && (tuse_rt_d < tnew_e)) ||
                      (rt_hit_m && (tuse_rt_d < tnew_m));

  assign stall = data_stall || md_stall;

  // Shadow pipeline advance: D->E (bubble on stall), E->M with Tnew ageing, M->W.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so each stage captures the pre-edge value of the one before.
    if (reset) begin
      a1_e   <= '0;
      a2_e   <= '0;
      a3_e   <= '0;
      we_e   <= 1'b0;
      tnew_e <= '0;
      a2_m   <= '0;
      a3_m   <= '0;
      we_m   <= 1'b0;
      tnew_m <= '0;
      a3_w   <= '0;
      we_w   <= 1'b0;
    end else begin
      if (stall) begin
        a1_e   <= '0;
        a2_e   <= '0;
        a3_e   <= '0;
        we_e   <= 1'b0;
        tnew_e <= '0;
      end else begin
        a1_e   <= a1_d;
        a2_e   <= a2_d;
        a3_e   <= a3_d;
        we_e   <= we_d;
        tnew_e <= tnew_d;
      end
      a2_m   <= a2_e;
      a3_m   <= a3_e;
      we_m   <= we_e;
      tnew_m <= (tnew_e != '0) ? tnew_e - T_W'(1) : '0;
      a3_w   <= a3_m;
      we_w   <= we_m;
    end
  end

`ifdef HAZARD_MD_EN
  logic [1:0] md_op_e;

  // md_op shadow in E; a stalled slot enters E as a non-MD bubble.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      md_op_e <= MD_NONE;
    end else begin
      md_op_e <= md_op_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk        (clk),
    .reset      (reset),
    .start_mult (md_op_e == MD_MULT),
    .start_div  (md_op_e == MD_DIV),
    .busy       (md_busy)
  );

  // Any HI/LO instruction in D waits while a mult/div is starting or running.
  assign md_stall = (md_op_d != MD_NONE) &&
                    (md_busy || (md_op_e == MD_MULT) || (md_op_e == MD_DIV));
`else
  logic unused_md;
  assign unused_md = ^{md_op_d, 32'(MULT_CYCLES), 32'(DIV_CYCLES)};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_tracked.sv
// tb_hazard_ctrl_tracked: directed vector table, multi-cycle MD/reset
// sequences and a randomized run against a behavioural model.
// Follows HAZARD_MD_EN in the same way as the design.
module tb_hazard_ctrl_tracked;
  import hazard_pkg::*;

  localparam int REG_AW = 5;
  localparam int T_W    = 3;
  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] a1_d, a2_d, a3_d;
  logic [T_W-1:0]    tuse_rs_d, tuse_rt_d, tnew_d;
  logic              we_d;
  logic [1:0]        md_op_d;
  logic [1:0]        fw_cmp_rs, fw_cmp_rt, fw_alu_rs, fw_alu_rt;
  logic              fw_dm_rt, stall, md_busy;

  always #5 clk = ~clk;

  hazard_ctrl_tracked #(
    .REG_AW      (REG_AW),
    .T_W         (T_W),
    .MULT_CYCLES (MULT_C),
    .DIV_CYCLES  (DIV_C)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a1_d      (a1_d),
    .a2_d      (a2_d),
    .tuse_rs_d (tuse_rs_d),
    .tuse_rt_d (tuse_rt_d),
    .a3_d      (a3_d),
    .we_d      (we_d),
    .tnew_d    (tnew_d),
    .md_op_d   (md_op_d),
    .fw_cmp_rs (fw_cmp_rs),
    .fw_cmp_rt (fw_cmp_rt),
    .fw_alu_rs (fw_alu_rs),
    .fw_alu_rt (fw_alu_rt),
    .fw_dm_rt  (fw_dm_rt),
    .stall     (stall),
    .md_busy   (md_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each in-flight instruction keeps its original Tnew; remaining latency is
  // derived from how many stages it has advanced past E.
  typedef struct {
    logic [4:0] a1, a2, a3;
    logic       we;
    int         tnew;
    int         md;
  } instr_t;

  typedef struct {
    int stall, cmp_rs, cmp_rt, alu_rs, alu_rt, dm, busy;
  } out_t;

  instr_t st_e, st_m, st_w;
  int     cyc = 0;
  int     busy_end = 0;

  function automatic instr_t nop_instr();
    instr_t n;
    n.a1 = '0; n.a2 = '0; n.a3 = '0; n.we = 1'b0; n.tnew = 0; n.md = 0;
    return n;
  endfunction

  function automatic int left(instr_t s, int age);
    if (age >= 2) return 0;
    return (s.tnew - age > 0) ? s.tnew - age : 0;
  endfunction

  function automatic bit writes(logic [4:0] addr, instr_t s);
    return s.we && s.a3 != 0 && s.a3 == addr;
  endfunction

  function automatic int cmp_src(logic [4:0] addr);
    if (writes(addr, st_e) && left(st_e, 0) == 0) return 3;
    if (writes(addr, st_m) && left(st_m, 1) == 0) return 2;
    if (writes(addr, st_w)) return 1;
    return 0;
  endfunction

  function automatic int alu_src(logic [4:0] addr);
    if (writes(addr, st_m) && left(st_m, 1) == 0) return 2;
    if (writes(addr, st_w)) return 1;
    return 0;
  endfunction

  function automatic bit must_wait(logic [4:0] addr, int tuse);
    return (writes(addr, st_e) && tuse < left(st_e, 0)) ||
           (writes(addr, st_m) && tuse < left(st_m, 1));
  endfunction

  function automatic out_t model_out();
    out_t o;
    bit   busy_now;
    bit   md_wait;
    busy_now = 1'b0;
    md_wait  = 1'b0;
`ifdef HAZARD_MD_EN
    busy_now = (cyc < busy_end);
    md_wait  = (md_op_d != 0) && (busy_now || st_e.md == 1 || st_e.md == 2);
`endif
    o.stall  = (must_wait(a1_d, int'(tuse_rs_d)) || must_wait(a2_d, int'(tuse_rt_d)) || md_wait) ? 1 : 0;
    o.cmp_rs = cmp_src(a1_d);
    o.cmp_rt = cmp_src(a2_d);
    o.alu_rs = alu_src(st_e.a1);
    o.alu_rt = alu_src(st_e.a2);
    o.dm     = writes(st_m.a2, st_w) ? 1 : 0;
    o.busy   = busy_now ? 1 : 0;
    return o;
  endfunction

  // One clock edge for both DUT and model; inputs move 1 time unit later.
  task automatic tick();
    out_t   pre;
    instr_t d;
    pre = model_out();
    d.a1 = a1_d; d.a2 = a2_d; d.a3 = a3_d; d.we = we_d;
    d.tnew = int'(tnew_d); d.md = int'(md_op_d);
    @(posedge clk);
    if (reset) begin
      st_e = nop_instr(); st_m = nop_instr(); st_w = nop_instr();
      cyc++;
      busy_end = cyc;
    end else begin
`ifdef HAZARD_MD_EN
      if ((st_e.md == 1 || st_e.md == 2) && !(cyc < busy_end))
        busy_end = cyc + 1 + ((st_e.md == 1) ? MULT_C : DIV_C);
`endif
      st_w = st_m;
      st_m = st_e;
      st_e = (pre.stall != 0) ? nop_instr() : d;
      cyc++;
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input int tr, input int tt,
                       input logic [4:0] a3, input logic we, input int tn, input int md);
    a1_d = a1; a2_d = a2; tuse_rs_d = T_W'(tr); tuse_rt_d = T_W'(tt);
    a3_d = a3; we_d = we; tnew_d = T_W'(tn); md_op_d = 2'(md);
  endtask

  task automatic check_all(input string tag, input out_t e);
    check({tag, "_stall"},  32'(stall),     32'(e.stall));
    check({tag, "_cmp_rs"}, 32'(fw_cmp_rs), 32'(e.cmp_rs));
    check({tag, "_cmp_rt"}, 32'(fw_cmp_rt), 32'(e.cmp_rt));
    check({tag, "_alu_rs"}, 32'(fw_alu_rs), 32'(e.alu_rs));
    check({tag, "_alu_rt"}, 32'(fw_alu_rt), 32'(e.alu_rt));
    check({tag, "_dm_rt"},  32'(fw_dm_rt),  32'(e.dm));
    check({tag, "_busy"},   32'(md_busy),   32'(e.busy));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0] a1, a2;
    int         tuse_rs, tuse_rt;
    logic [4:0] a3;
    logic       we;
    int         tnew;
    int         stall, cmp_rs, cmp_rt, alu_rs, alu_rt, dm;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  initial begin
    out_t zero;
    out_t exp_o;
    int   n;
    logic [4:0] r1, r2, r3;

    zero = '{0, 0, 0, 0, 0, 0, 0};

    //            a1 a2 tr tt a3 we tn  st crs crt ars art dm
    // addu $3 (tnew 1) then beq on $3 (tuse 0)
    vecs[0]  = '{5'd1, 5'd2, 1, 1, 5'd3, 1'b1, 1,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{5'd3, 5'd0, 0, 0, 5'd0, 1'b0, 0,  1, 0, 0, 0, 0, 0};
    vecs[2]  = '{5'd3, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 2, 0, 0, 0, 0};
    vecs[3]  = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 1, 0, 0};
    vecs[4]  = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};
    // lw $5 (tnew 2) then addu reading $5 (tuse 1); lw sits in W once addu is in E
    vecs[5]  = '{5'd4, 5'd0, 1, 1, 5'd5, 1'b1, 2,  0, 0, 0, 0, 0, 0};
    vecs[6]  = '{5'd5, 5'd6, 1, 1, 5'd7, 1'b1, 1,  1, 0, 0, 0, 0, 0};
    vecs[7]  = '{5'd5, 5'd6, 1, 1, 5'd7, 1'b1, 1,  0, 0, 0, 0, 0, 0};
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 1, 0, 0};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};
    // write to $0 followed by readers of $0
    vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b1, 1,  0, 0, 0, 0, 0, 0};
    vecs[11] = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};
    vecs[12] = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};
    // addu $8 then sw with rt=$8: ALU fwd from M, then store data from W
    vecs[13] = '{5'd1, 5'd2, 1, 1, 5'd8, 1'b1, 1,  0, 0, 0, 0, 0, 0};
    vecs[14] = '{5'd9, 5'd8, 1, 2, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};
    vecs[15] = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 2, 0};
    vecs[16] = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 1};
    // same shape with $0: a2_M = a3_W = 0 must not forward
    vecs[17] = '{5'd1, 5'd2, 1, 1, 5'd0, 1'b1, 1,  0, 0, 0, 0, 0, 0};
    vecs[18] = '{5'd9, 5'd0, 1, 2, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};
    vecs[19] = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};
    vecs[20] = '{5'd0, 5'd0, 0, 0, 5'd0, 1'b0, 0,  0, 0, 0, 0, 0, 0};

    st_e = nop_instr(); st_m = nop_instr(); st_w = nop_instr();

    // Reset, then every output must be 0 with idle D inputs.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1'b0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    #2;
    check_all("reset", zero);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].a1, vecs[i].a2, vecs[i].tuse_rs, vecs[i].tuse_rt,
            vecs[i].a3, vecs[i].we, vecs[i].tnew, 0);
      #2;
      exp_o = '{vecs[i].stall, vecs[i].cmp_rs, vecs[i].cmp_rt,
                vecs[i].alu_rs, vecs[i].alu_rt, vecs[i].dm, 0};
      check_all($sformatf("vec%0d", i), exp_o);
      tick();
    end

    // mult followed directly by mflo.
    drive(0, 0, 0, 0, 0, 1'b0, 0, 1);
    #2;
    check("mult_issue_stall", 32'(stall), 32'd0);
    tick();
    drive(0, 0, 0, 0, 5'd2, 1'b1, 1, 3);
    #2;
`ifdef HAZARD_MD_EN
    check("mflo_busy_first", 32'(md_busy), 32'd0);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
      #2;
    end
    check("mflo_stall_cycles", 32'(n), 32'(MULT_C + 1));
    check("mflo_busy_after", 32'(md_busy), 32'd0);
`else
    check("mflo_no_md_stall", 32'(stall), 32'd0);
    check("mflo_no_md_busy", 32'(md_busy), 32'd0);
`endif
    tick();

    // div in progress, reset pulsed for one cycle.
    drive(0, 0, 0, 0, 0, 1'b0, 0, 2);
    tick();
    drive(0, 0, 0, 0, 0, 1'b0, 0, 0);
    tick();
    tick();
    tick();
    #2;
`ifdef HAZARD_MD_EN
    check("div_busy", 32'(md_busy), 32'd1);
`else
    check("div_busy_off", 32'(md_busy), 32'd0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check("div_reset_busy", 32'(md_busy), 32'd0);
    check("div_reset_stall", 32'(stall), 32'd0);
    drive(0, 0, 0, 0, 0, 1'b0, 0, 3);
    #2;
    check("div_reset_mfhi_stall", 32'(stall), 32'd0);
    tick();

    // Randomized run; a stalled D instruction is held like the datapath does.
    for (int c = 0; c < 3000; c++) begin
      if (c == 0 || stall !== 1'b1) begin
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        r3 = 5'($urandom_range(0, 3));
        drive(r1, r2, $urandom_range(0, 3), $urandom_range(0, 3), r3, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), ($urandom_range(0, 7) < 6) ? 0 : $urandom_range(1, 3));
      end
      reset = ($urandom_range(0, 99) == 0);
      #2;
      exp_o = model_out();
      check_all($sformatf("rand%0d", c), exp_o);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
